// File: rtl/memctrl_if.sv
// Data-memory handshake bundle between the memory-stage controller (master)
// and the data memory (slave).
interface memctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/memctrl.sv
// Memory-stage controller: IDLE->WAIT->DONE access sequencer with timeout,
// pipeline stall generation and branch/jump PC-source resolution.
module memctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwr,
  input  logic              memrd,
  input  logic              bbne,
  input  logic              bbeq,
  input  logic              bblez,
  input  logic              bbgtz,
  input  logic              jump,
  input  logic              zero,
  input  logic              neg,
  input  logic [31:0]       addrin,
  input  logic [31:0]       wdatain,
  memctrl_if.master         dmem,
  output logic [31:0]       rdataout,
  output logic              stall,
  output logic [1:0]        pcsrc,
  output logic              flush,
  output logic              memerr
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (memrd || memwr) begin
          state_q <= S_WAIT;
          cnt_q   <= 4'd0;
          req_q   <= 1'b1;
          we_q    <= memwr;
          addr_q  <= addrin;
          wdata_q <= wdatain;
        end
        S_WAIT: begin
          // An ack on the final allowed cycle beats the timeout.
          if (dmem.dmem_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            if (!we_q) rdata_q <= dmem.dmem_rdata;
          end else if (cnt_q == 4'd14) begin
            state_q <= S_DONE;
            cnt_q   <= 4'd15;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign rdataout        = rdata_q;
  assign memerr          = err_q;

  // While rst_n is low the combinational outputs behave as in IDLE.
  logic st_idle, st_wait, taken;
  assign st_idle = !rst_n || (state_q == S_IDLE);
  assign st_wait = rst_n && (state_q == S_WAIT);
  assign stall   = (st_idle && (memrd || memwr)) || st_wait;

  assign taken = (bbeq & zero) | (bbne & ~zero) | (bblez & (zero | neg)) |
                 (bbgtz & ~zero & ~neg);

  always_comb begin
    pcsrc = 2'b00;
    flush = 1'b0;
    if (!stall) begin
      if (jump) begin
        pcsrc = 2'b10;
        flush = 1'b1;
      end else if (taken) begin
        pcsrc = 2'b01;
        flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl: loads, stores, timeout, ack/timeout race,
// branch resolution and reset during an access.
module tb_memctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        memwr, memrd, bbne, bbeq, bblez, bbgtz, jump, zero, neg;
  logic [31:0] addrin, wdatain, rdataout;
  logic        stall, flush, memerr;
  logic [1:0]  pcsrc;
  int          ncmp = 0;
  int          nfail = 0;

  memctrl_if dmem_if ();

  memctrl dut (
    .clk(clk), .rst_n(rst_n), .memwr(memwr), .memrd(memrd), .bbne(bbne),
    .bbeq(bbeq), .bblez(bblez), .bbgtz(bbgtz), .jump(jump), .zero(zero),
    .neg(neg), .addrin(addrin), .wdatain(wdatain), .dmem(dmem_if),
    .rdataout(rdataout), .stall(stall), .pcsrc(pcsrc), .flush(flush),
    .memerr(memerr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; memwr = 0; memrd = 0; bbne = 0; bbeq = 0; bblez = 0;
    bbgtz = 0; jump = 0; zero = 0; neg = 0; addrin = 0; wdatain = 0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'd0;
    tick(); tick();
    chk("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("rst_rdata", rdataout, 32'd0);
    chk("rst_err", {31'd0, memerr}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    jump = 1; #1;
    chk("rst_pcsrc_jump", {30'd0, pcsrc}, 32'd2);
    jump = 0;
    rst_n = 1'b1;
    tick();

    // Load, ack on 3rd WAIT cycle
    memrd = 1; addrin = 32'h100; #1;
    chk("ld_idle_stall", {31'd0, stall}, 32'd1);
    chk("ld_idle_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    tick();
    chk("ld_w1_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    chk("ld_w1_we", {31'd0, dmem_if.dmem_we}, 32'd0);
    chk("ld_w1_addr", dmem_if.dmem_addr, 32'h100);
    chk("ld_w1_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("ld_w2_stall", {31'd0, stall}, 32'd1);
    tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hDEADBEEF; #1;
    chk("ld_w3_stall", {31'd0, stall}, 32'd1);
    chk("ld_w3_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    tick();
    dmem_if.dmem_ack = 0; memrd = 0; #1;
    chk("ld_done_stall", {31'd0, stall}, 32'd0);
    chk("ld_done_rdata", rdataout, 32'hDEADBEEF);
    chk("ld_done_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    tick();
    chk("ld_idle2_rdata", rdataout, 32'hDEADBEEF);

    // Store, ack on 1st WAIT cycle
    memwr = 1; addrin = 32'h200; wdatain = 32'h12345678; #1;
    chk("st_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h0BADF00D; #1;
    chk("st_w1_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    chk("st_w1_we", {31'd0, dmem_if.dmem_we}, 32'd1);
    chk("st_w1_wdata", dmem_if.dmem_wdata, 32'h12345678);
    chk("st_w1_addr", dmem_if.dmem_addr, 32'h200);
    tick();
    dmem_if.dmem_ack = 0; memwr = 0; #1;
    chk("st_done_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("st_done_we", {31'd0, dmem_if.dmem_we}, 32'd0);
    chk("st_done_rdata", rdataout, 32'hDEADBEEF);
    tick();

    // Branch deferred behind a load
    memrd = 1; addrin = 32'h300; bbeq = 1; zero = 1; #1;
    chk("bs_idle_pcsrc", {30'd0, pcsrc}, 32'd0);
    chk("bs_idle_flush", {31'd0, flush}, 32'd0);
    tick();
    chk("bs_w1_pcsrc", {30'd0, pcsrc}, 32'd0);
    chk("bs_w1_flush", {31'd0, flush}, 32'd0);
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_if.dmem_ack = 0; memrd = 0; #1;
    chk("bs_done_pcsrc", {30'd0, pcsrc}, 32'd1);
    chk("bs_done_flush", {31'd0, flush}, 32'd1);
    chk("bs_done_rdata", rdataout, 32'hCAFEF00D);
    tick();
    bbeq = 0; zero = 0;

    // Branch vectors, no memory op
    bbeq = 1; zero = 1; #1;
    chk("br_eq_pcsrc", {30'd0, pcsrc}, 32'd1);
    chk("br_eq_flush", {31'd0, flush}, 32'd1);
    bbeq = 0; zero = 0; bblez = 1; neg = 1; #1;
    chk("br_lez_pcsrc", {30'd0, pcsrc}, 32'd1);
    bblez = 0; neg = 0; bbgtz = 1; zero = 1; #1;
    chk("br_gtz_pcsrc", {30'd0, pcsrc}, 32'd0);
    chk("br_gtz_flush", {31'd0, flush}, 32'd0);
    bbgtz = 0; zero = 0; jump = 1; bbne = 1; #1;
    chk("br_jmp_pcsrc", {30'd0, pcsrc}, 32'd2);
    chk("br_jmp_flush", {31'd0, flush}, 32'd1);
    jump = 0; #1;
    chk("br_ne_pcsrc", {30'd0, pcsrc}, 32'd1);
    bbne = 0; bbgtz = 1; bbeq = 1; zero = 0; neg = 0; #1;
    chk("br_or_pcsrc", {30'd0, pcsrc}, 32'd1);
    bbgtz = 0; bbeq = 0; #1;
    chk("br_none_pcsrc", {30'd0, pcsrc}, 32'd0);

    // Ack on the 15th WAIT cycle wins over timeout
    memrd = 1; addrin = 32'h380;
    tick();
    for (int k = 1; k < 15; k++) tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h5A5A5A5A; #1;
    chk("race_w15_req", {31'd0, dmem_if.dmem_req}, 32'd1);
    tick();
    dmem_if.dmem_ack = 0; memrd = 0; #1;
    chk("race_done_rdata", rdataout, 32'h5A5A5A5A);
    chk("race_done_err", {31'd0, memerr}, 32'd0);
    chk("race_done_stall", {31'd0, stall}, 32'd0);
    tick();

    // Timeout: no ack at all
    memrd = 1; addrin = 32'h400;
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk("to_wait_req", {31'd0, dmem_if.dmem_req}, 32'd1);
      chk("to_wait_err", {31'd0, memerr}, 32'd0);
      tick();
    end
    memrd = 0; #1;
    chk("to_done_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("to_done_err", {31'd0, memerr}, 32'd1);
    chk("to_done_rdata", rdataout, 32'd0);
    chk("to_done_stall", {31'd0, stall}, 32'd0);
    tick();

    // memerr remains set across a later store
    memwr = 1; addrin = 32'h500; wdatain = 32'h1;
    tick();
    dmem_if.dmem_ack = 1;
    tick();
    dmem_if.dmem_ack = 0; memwr = 0; #1;
    chk("sticky_err", {31'd0, memerr}, 32'd1);
    tick();

    // Reset on 2nd WAIT cycle with ack high
    memrd = 1; addrin = 32'h600;
    tick();
    tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hFFFF0000; rst_n = 0;
    tick();
    dmem_if.dmem_ack = 0; memrd = 0; #1;
    chk("rw_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    chk("rw_rdata", rdataout, 32'd0);
    chk("rw_err", {31'd0, memerr}, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    rst_n = 1;
    tick();
    memrd = 1; #1;
    chk("rw_idle_stall", {31'd0, stall}, 32'd1);
    chk("rw_idle_req", {31'd0, dmem_if.dmem_req}, 32'd0);
    memrd = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
